// File: rtl/regsched_pkg.sv
// Shared types for the register-file port scheduler: FSM states, port-select encoding
// and default widths.
package regsched_pkg;

    localparam int unsigned DefDataW = 32;
    localparam int unsigned DefAddrW = 6;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StResp
    } state_e;

    typedef enum logic [2:0] {
        PselNone,
        PselWb0,
        PselWb1,
        PselRd0,
        PselRd1,
        PselRd2
    } psel_e;

    function automatic psel_e rd_sel(input int idx);
        case (idx)
            0:       return PselRd0;
            1:       return PselRd1;
            default: return PselRd2;
        endcase
    endfunction

    function automatic logic is_rd(input psel_e s);
        return (s == PselRd0) || (s == PselRd1) || (s == PselRd2);
    endfunction

endpackage

// File: rtl/regsched_port_alloc.sv
// Combinational grant logic for the two BRAM ports: write-backs first (wb0 older), then
// pending operand reads in index order, filling port A before port B.
module regsched_port_alloc
    import regsched_pkg::*;
#(
    parameter int unsigned ADDRW = DefAddrW
) (
    input  logic                  en,
    input  logic                  starve,
    input  logic [2:0]            pend,
    input  logic [2:0][ADDRW-1:0] op_addr,
    input  logic                  wb0_valid,
    input  logic [ADDRW-1:0]      wb0_addr,
    input  logic                  wb1_valid,
    input  logic [ADDRW-1:0]      wb1_addr,
    output psel_e                 sel_a,
    output psel_e                 sel_b,
    output logic                  wb0_ready,
    output logic                  wb1_ready
);

    logic [2:0] blocked;

    always_comb begin
        sel_a     = PselNone;
        sel_b     = PselNone;
        wb0_ready = 1'b0;
        wb1_ready = 1'b0;
        blocked   = '0;

        if (en && !starve) begin
            if (wb0_valid) begin
                wb0_ready = 1'b1;
                if (wb0_addr != '0) begin
                    sel_a = PselWb0;
                end
            end
            // x0 writes are free; a same-address wb1 waits so wb0's value cannot win late
            if (wb1_valid) begin
                if (wb1_addr == '0) begin
                    wb1_ready = 1'b1;
                end else if (!(wb0_valid && (wb0_addr == wb1_addr))) begin
                    wb1_ready = 1'b1;
                    if (sel_a == PselNone) begin
                        sel_a = PselWb1;
                    end else begin
                        sel_b = PselWb1;
                    end
                end
            end
        end

        for (int i = 0; i < 3; i++) begin
            // An operand hit by a granted write takes the write data instead of reading
            blocked[i] = (wb0_ready && (wb0_addr == op_addr[i])) ||
                         (wb1_ready && (wb1_addr == op_addr[i]));
            if (en && pend[i] && !blocked[i]) begin
                if (sel_a == PselNone) begin
                    sel_a = rd_sel(i);
                end else if (sel_b == PselNone) begin
                    sel_b = rd_sel(i);
                end
            end
        end
    end

endmodule

// File: rtl/regfile_port_sched.sv
// Dual-port register-file BRAM scheduler: two write-backs and one 3-operand read bundle.
// Optional REGSCHED_STALL_CNT_EN adds a 32-bit stall_cnt output.
module regfile_port_sched
    import regsched_pkg::*;
#(
    parameter int unsigned DATAW      = DefDataW,
    parameter int unsigned ADDRW      = DefAddrW,
    parameter int unsigned STARVE_LIM = 4
) (
`ifdef REGSCHED_STALL_CNT_EN
    output logic [31:0]      stall_cnt,
`endif
    input  logic             clk,
    input  logic             rstn,
    input  logic             wb0_valid,
    output logic             wb0_ready,
    input  logic [ADDRW-1:0] wb0_addr,
    input  logic [DATAW-1:0] wb0_data,
    input  logic             wb1_valid,
    output logic             wb1_ready,
    input  logic [ADDRW-1:0] wb1_addr,
    input  logic [DATAW-1:0] wb1_data,
    input  logic             rd_valid,
    output logic             rd_ready,
    input  logic [2:0]       rd_en,
    input  logic [ADDRW-1:0] rd_addr0,
    input  logic [ADDRW-1:0] rd_addr1,
    input  logic [ADDRW-1:0] rd_addr2,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DATAW-1:0] rsp_data0,
    output logic [DATAW-1:0] rsp_data1,
    output logic [DATAW-1:0] rsp_data2,
    output logic             bram_wea,
    output logic             bram_web,
    output logic [ADDRW-1:0] bram_addra,
    output logic [ADDRW-1:0] bram_addrb,
    output logic [DATAW-1:0] bram_dina,
    output logic [DATAW-1:0] bram_dinb,
    input  logic [DATAW-1:0] bram_douta,
    input  logic [DATAW-1:0] bram_doutb
);

    localparam int unsigned CntW = (STARVE_LIM < 2) ? 1 : $clog2(STARVE_LIM + 1);

    state_e                state_q, state_d;
    logic [2:0][ADDRW-1:0] op_addr_q, op_addr_d, rd_addr_v;
    logic [2:0][DATAW-1:0] op_data_q, op_data_d;
    logic [2:0]            use_q, use_d, fetched_q, fetched_d;
    logic [2:0]            inflight, pend, hit0, hit1;
    psel_e                 sel_a, sel_b, tag_a_q, tag_a_d, tag_b_q, tag_b_d;
    logic [CntW-1:0]       starve_q, starve_d;
    logic                  starve, issue, accept;
    psel_e                 psel [2];
    logic [1:0]            we;
    logic [1:0][ADDRW-1:0] addr;
    logic [1:0][DATAW-1:0] din;

    assign rd_addr_v = {rd_addr2, rd_addr1, rd_addr0};
    assign rd_ready  = rstn && (state_q == StIdle);
    assign accept    = rd_valid && rd_ready;
    assign starve    = (STARVE_LIM != 0) && (starve_q == CntW'(STARVE_LIM));
    assign issue     = is_rd(sel_a) || is_rd(sel_b);

    always_comb begin
        inflight = '0;
        pend     = '0;
        hit0     = '0;
        hit1     = '0;
        for (int i = 0; i < 3; i++) begin
            inflight[i] = (tag_a_q == rd_sel(i)) || (tag_b_q == rd_sel(i));
            pend[i]     = (state_q == StCollect) && use_q[i] && !fetched_q[i] && !inflight[i];
            hit0[i]     = (state_q == StCollect) && use_q[i] && wb0_ready &&
                          (wb0_addr == op_addr_q[i]);
            hit1[i]     = (state_q == StCollect) && use_q[i] && wb1_ready &&
                          (wb1_addr == op_addr_q[i]);
        end
    end

    regsched_port_alloc #(
        .ADDRW (ADDRW)
    ) u_port_alloc (
        .en        (rstn),
        .starve    (starve),
        .pend      (pend),
        .op_addr   (op_addr_q),
        .wb0_valid (wb0_valid),
        .wb0_addr  (wb0_addr),
        .wb1_valid (wb1_valid),
        .wb1_addr  (wb1_addr),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .wb0_ready (wb0_ready),
        .wb1_ready (wb1_ready)
    );

    always_comb begin
        state_d   = state_q;
        op_addr_d = op_addr_q;
        op_data_d = op_data_q;
        use_d     = use_q;
        fetched_d = fetched_q;
        tag_a_d   = PselNone;
        tag_b_d   = PselNone;
        starve_d  = '0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    for (int i = 0; i < 3; i++) begin
                        use_d[i] = rd_en[i] && (rd_addr_v[i] != '0);
                    end
                    op_addr_d = rd_addr_v;
                    op_data_d = '0;
                    fetched_d = ~use_d;
                    state_d   = (use_d == 3'b000) ? StResp : StCollect;
                end
            end
            StCollect: begin
                for (int i = 0; i < 3; i++) begin
                    if (inflight[i]) begin
                        op_data_d[i] = (tag_a_q == rd_sel(i)) ? bram_douta : bram_doutb;
                        fetched_d[i] = 1'b1;
                    end
                    // Snooped write data is newer than anything the BRAM returns this cycle
                    if (hit0[i]) begin
                        op_data_d[i] = wb0_data;
                        fetched_d[i] = 1'b1;
                    end
                    if (hit1[i]) begin
                        op_data_d[i] = wb1_data;
                        fetched_d[i] = 1'b1;
                    end
                end
                if (is_rd(sel_a)) tag_a_d = sel_a;
                if (is_rd(sel_b)) tag_b_d = sel_b;
                if (issue) begin
                    starve_d = '0;
                end else if ((pend != '0) && (starve_q != CntW'(STARVE_LIM))) begin
                    starve_d = starve_q + CntW'(1);
                end else begin
                    starve_d = starve_q;
                end
                // An issued read leaves its operand unfetched, so this implies nothing in flight
                if (fetched_d == 3'b111) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= StIdle;
            op_addr_q <= '0;
            op_data_q <= '0;
            use_q     <= '0;
            fetched_q <= '0;
            tag_a_q   <= PselNone;
            tag_b_q   <= PselNone;
            starve_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_addr_q <= op_addr_d;
            op_data_q <= op_data_d;
            use_q     <= use_d;
            fetched_q <= fetched_d;
            tag_a_q   <= tag_a_d;
            tag_b_q   <= tag_b_d;
            starve_q  <= starve_d;
        end
    end

    assign psel[0] = sel_a;
    assign psel[1] = sel_b;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            we[p]   = 1'b0;
            addr[p] = '0;
            din[p]  = '0;
            unique case (psel[p])
                PselWb0: begin
                    we[p]   = 1'b1;
                    addr[p] = wb0_addr;
                    din[p]  = wb0_data;
                end
                PselWb1: begin
                    we[p]   = 1'b1;
                    addr[p] = wb1_addr;
                    din[p]  = wb1_data;
                end
                PselRd0: addr[p] = op_addr_q[0];
                PselRd1: addr[p] = op_addr_q[1];
                PselRd2: addr[p] = op_addr_q[2];
                default: ;
            endcase
        end
    end

    assign bram_wea   = we[0];
    assign bram_web   = we[1];
    assign bram_addra = addr[0];
    assign bram_addrb = addr[1];
    assign bram_dina  = din[0];
    assign bram_dinb  = din[1];

    assign rsp_valid = (state_q == StResp);
    assign rsp_data0 = op_data_q[0];
    assign rsp_data1 = op_data_q[1];
    assign rsp_data2 = op_data_q[2];

`ifdef REGSCHED_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
        end else if ((wb0_valid && !wb0_ready) || (wb1_valid && !wb1_ready) ||
                     (state_q == StCollect)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_port_sched.sv
// Directed bench for regfile_port_sched with a behavioural true-dual-port BRAM model.
module tb_regfile_port_sched;

    logic        clk = 1'b0;
    logic        rstn;
    logic        wb0_valid, wb0_ready, wb1_valid, wb1_ready;
    logic [5:0]  wb0_addr, wb1_addr;
    logic [31:0] wb0_data, wb1_data;
    logic        rd_valid, rd_ready;
    logic [2:0]  rd_en;
    logic [5:0]  rd_addr0, rd_addr1, rd_addr2;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data0, rsp_data1, rsp_data2;
    logic        bram_wea, bram_web;
    logic [5:0]  bram_addra, bram_addrb;
    logic [31:0] bram_dina, bram_dinb, bram_douta, bram_doutb;
`ifdef REGSCHED_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    logic [31:0] mem [64];
    logic        bd_we;
    logic [5:0]  bd_addr;
    logic [31:0] bd_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_port_sched dut (
`ifdef REGSCHED_STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .clk        (clk),
        .rstn       (rstn),
        .wb0_valid  (wb0_valid),
        .wb0_ready  (wb0_ready),
        .wb0_addr   (wb0_addr),
        .wb0_data   (wb0_data),
        .wb1_valid  (wb1_valid),
        .wb1_ready  (wb1_ready),
        .wb1_addr   (wb1_addr),
        .wb1_data   (wb1_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_en      (rd_en),
        .rd_addr0   (rd_addr0),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data0  (rsp_data0),
        .rsp_data1  (rsp_data1),
        .rsp_data2  (rsp_data2),
        .bram_wea   (bram_wea),
        .bram_web   (bram_web),
        .bram_addra (bram_addra),
        .bram_addrb (bram_addrb),
        .bram_dina  (bram_dina),
        .bram_dinb  (bram_dinb),
        .bram_douta (bram_douta),
        .bram_doutb (bram_doutb)
    );

    // Read-first BRAM with one cycle of read latency plus a backdoor preload port
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (bram_wea) mem[bram_addra] <= bram_dina;
        if (bram_web) mem[bram_addrb] <= bram_dinb;
        bram_douta <= mem[bram_addra];
        bram_doutb <= mem[bram_addrb];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic poke(input logic [5:0] a, input logic [31:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        tick();
        bd_we   = 1'b0;
    endtask

    task automatic wait_rsp(input int lim, input string tag);
        int n = 0;
        while (!rsp_valid && n < lim) begin
            tick();
            n++;
        end
        check(tag, 64'(rsp_valid), 64'd1);
    endtask

    task automatic issue_bundle(input logic [2:0] en, input logic [5:0] a0,
                                input logic [5:0] a1, input logic [5:0] a2);
        rd_valid = 1'b1;
        rd_en    = en;
        rd_addr0 = a0;
        rd_addr1 = a1;
        rd_addr2 = a2;
        tick();
        rd_valid = 1'b0;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        wb0_valid = 1'b0; wb0_addr = '0; wb0_data = '0;
        wb1_valid = 1'b0; wb1_addr = '0; wb1_data = '0;
        rd_valid = 1'b0; rd_en = '0; rd_addr0 = '0; rd_addr1 = '0; rd_addr2 = '0;
        rsp_ready = 1'b0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        tick();
        tick();

        // Reset state with a write-back knocking
        wb0_valid = 1'b1; wb0_addr = 6'd3; wb0_data = 32'h1;
        settle();
        check("rst_rd_ready", 64'(rd_ready), 64'd0);
        check("rst_wb0_ready", 64'(wb0_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data0", 64'(rsp_data0), 64'd0);
        check("rst_wea", 64'(bram_wea), 64'd0);
        check("rst_addra", 64'(bram_addra), 64'd0);
        wb0_valid = 1'b0;
        rstn = 1'b1;
        tick();
        check("idle_rd_ready", 64'(rd_ready), 64'd1);

        poke(6'd5, 32'h55);
        poke(6'd6, 32'h66);
        poke(6'd7, 32'h77);
        poke(6'd12, 32'h1212);
        poke(6'd30, 32'h3030);

        // Plain three-operand bundle
        issue_bundle(3'b111, 6'd5, 6'd6, 6'd7);
        settle();
        check("t1_addra", 64'(bram_addra), 64'd5);
        check("t1_addrb", 64'(bram_addrb), 64'd6);
        check("t1_wea", 64'({bram_wea, bram_web}), 64'd0);
        check("t1_rd_ready", 64'(rd_ready), 64'd0);
        tick();
        check("t1_addra2", 64'(bram_addra), 64'd7);
        check("t1_rsp_early", 64'(rsp_valid), 64'd0);
        wait_rsp(6, "t1_rsp_timeout");
        check("t1_d0", 64'(rsp_data0), 64'h55);
        check("t1_d1", 64'(rsp_data1), 64'h66);
        check("t1_d2", 64'(rsp_data2), 64'h77);
        finish_rsp();
        check("t1_back_idle", 64'(rd_ready), 64'd1);

        // x0 operand and x0 write
        rd_valid = 1'b1; rd_en = 3'b001; rd_addr0 = 6'd0; rd_addr1 = 6'd5; rd_addr2 = 6'd6;
        settle();
        check("t2_acc_addra", 64'(bram_addra), 64'd0);
        tick();
        rd_valid = 1'b0;
        check("t2_rsp_valid", 64'(rsp_valid), 64'd1);
        check("t2_d0", 64'(rsp_data0), 64'd0);
        check("t2_d1", 64'(rsp_data1), 64'd0);
        wb0_valid = 1'b1; wb0_addr = 6'd0; wb0_data = 32'hdead;
        settle();
        check("t2_wb0_ready", 64'(wb0_ready), 64'd1);
        check("t2_wea", 64'(bram_wea), 64'd0);
        finish_rsp();
        wb0_valid = 1'b0;

        // Same-address write-backs: wb0 first, wb1 a cycle later
        wb0_valid = 1'b1; wb0_addr = 6'd9; wb0_data = 32'h11;
        wb1_valid = 1'b1; wb1_addr = 6'd9; wb1_data = 32'h22;
        settle();
        check("t3_c1_ready", 64'({wb0_ready, wb1_ready}), 64'b10);
        check("t3_c1_wea", 64'({bram_wea, bram_web}), 64'b10);
        check("t3_c1_addra", 64'(bram_addra), 64'd9);
        check("t3_c1_dina", 64'(bram_dina), 64'h11);
        tick();
        wb0_valid = 1'b0;
        settle();
        check("t3_c2_wb1_ready", 64'(wb1_ready), 64'd1);
        check("t3_c2_dina", 64'(bram_dina), 64'h22);
        tick();
        wb1_valid = 1'b0;
        tick();
        check("t3_mem9", 64'(mem[9]), 64'h22);

        // Snoop in the data-return cycle beats the stale BRAM value
        issue_bundle(3'b001, 6'd12, 6'd0, 6'd0);
        settle();
        check("t4_issue_addra", 64'(bram_addra), 64'd12);
        check("t4_issue_wea", 64'(bram_wea), 64'd0);
        tick();
        wb1_valid = 1'b1; wb1_addr = 6'd12; wb1_data = 32'hABCD;
        settle();
        check("t4_wb1_ready", 64'(wb1_ready), 64'd1);
        check("t4_wr_addra", 64'(bram_addra), 64'd12);
        tick();
        wb1_valid = 1'b0;
        wait_rsp(4, "t4_rsp_timeout");
        check("t4_d0", 64'(rsp_data0), 64'hABCD);
        finish_rsp();

        // Starvation guard: writes every cycle, reads forced through on the fifth cycle
        wb0_valid = 1'b1; wb0_addr = 6'd20; wb0_data = 32'h2001;
        wb1_valid = 1'b1; wb1_addr = 6'd21; wb1_data = 32'h2101;
        issue_bundle(3'b111, 6'd5, 6'd6, 6'd7);
        for (int c = 1; c <= 4; c++) begin
            settle();
            check("t5_wb_granted", 64'({wb0_ready, wb1_ready}), 64'b11);
            tick();
        end
        settle();
        check("t5_starve_ready", 64'({wb0_ready, wb1_ready}), 64'b00);
        check("t5_starve_we", 64'({bram_wea, bram_web}), 64'b00);
        check("t5_starve_addra", 64'(bram_addra), 64'd5);
        check("t5_starve_addrb", 64'(bram_addrb), 64'd6);
        wait_rsp(30, "t5_rsp_timeout");
        check("t5_d0", 64'(rsp_data0), 64'h55);
        check("t5_d1", 64'(rsp_data1), 64'h66);
        check("t5_d2", 64'(rsp_data2), 64'h77);
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
        finish_rsp();
        check("t5_mem20", 64'(mem[20]), 64'h2001);

        // Backpressure: response held stable, and RESP does not snoop
        issue_bundle(3'b011, 6'd5, 6'd6, 6'd0);
        wait_rsp(8, "t6_rsp_timeout");
        wb0_valid = 1'b1; wb0_addr = 6'd5; wb0_data = 32'h9999;
        for (int c = 0; c < 10; c++) begin
            settle();
            check("t6_valid", 64'(rsp_valid), 64'd1);
            check("t6_d0", 64'(rsp_data0), 64'h55);
            check("t6_d1", 64'(rsp_data1), 64'h66);
            check("t6_rd_ready", 64'(rd_ready), 64'd0);
            tick();
        end
        wb0_valid = 1'b0;
        finish_rsp();

        // Reset in the middle of a collect drops the bundle
        issue_bundle(3'b011, 6'd6, 6'd7, 6'd0);
        settle();
        check("t7_collect", 64'(rd_ready), 64'd0);
        rstn = 1'b0;
        wb0_valid = 1'b1; wb0_addr = 6'd30; wb0_data = 32'hBAD;
        settle();
        check("t7_rst_wb0_ready", 64'(wb0_ready), 64'd0);
        check("t7_rst_we", 64'({bram_wea, bram_web}), 64'b00);
        tick();
        check("t7_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t7_d0", 64'(rsp_data0), 64'd0);
        check("t7_rd_ready", 64'(rd_ready), 64'd0);
        rstn = 1'b1;
        wb0_valid = 1'b0;
        tick();
        check("t7_idle", 64'(rd_ready), 64'd1);
        check("t7_idle_rsp", 64'(rsp_valid), 64'd0);
        check("t7_mem30", 64'(mem[30]), 64'h3030);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
